// File: rtl/sha3_pkg.sv
// Shared lane types and helpers for the Keccak theta datapath.
// Lanes are carried at the widest Keccak-f width and masked down to LANE_W.
package sha3_pkg;

  localparam int SHA3_MAX_LANE_W = 64;
  localparam int NUM_LANES       = 5;

  typedef logic [SHA3_MAX_LANE_W-1:0] lane_t;
  typedef lane_t [0:NUM_LANES-1]      row_t;

  function automatic lane_t lane_mask(input int unsigned w);
    return (w >= SHA3_MAX_LANE_W) ? '1 : ((lane_t'(1) << w) - lane_t'(1));
  endfunction

  // Rotate left by one within the low w bits; upper bits of v must be zero.
  // For w=1 this degenerates to the identity.
  function automatic lane_t rotl1(input lane_t v, input int unsigned w);
    return ((v << 1) | (v >> (w - 1))) & lane_mask(w);
  endfunction

endpackage

// File: rtl/sha3_theta_colpar.sv
// Combinational column parity for theta: C[x] = XOR over y of A[y][x].
// Shared by the two-stage front end and the single-stage variant.
module sha3_theta_colpar
  import sha3_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic [NUM_LANES-1:0][NUM_LANES-1:0][LANE_W-1:0] a,
  output logic [NUM_LANES-1:0][LANE_W-1:0]                c
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional or accumulating logic, otherwise synthesis infers latches.
    c = '0;
    for (int x = 0; x < NUM_LANES; x++) begin
      for (int y = 0; y < NUM_LANES; y++) begin
        c[x] = c[x] ^ a[y][x];
      end
    end
  end

endmodule

// File: rtl/sha3_theta_pipe.sv
// Keccak theta step behind a valid/ready pipeline of 1 or 2 register stages.
// Optional `SHA3_THETA_BYPASS_EN adds a per-state bypass bit (A' = A).
module sha3_theta_pipe
  import sha3_pkg::*;
#(
  parameter int LANE_W      = 64,
  parameter int PIPE_STAGES = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]    isa,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]    isb,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]    isc,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]    isd,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]    ise,
  input  logic                                sample,
  output logic                                sample_ready,
  output logic [NUM_LANES-1:0][LANE_W-1:0]    osa,
  output logic [NUM_LANES-1:0][LANE_W-1:0]    osb,
  output logic [NUM_LANES-1:0][LANE_W-1:0]    osc,
  output logic [NUM_LANES-1:0][LANE_W-1:0]    osd,
  output logic [NUM_LANES-1:0][LANE_W-1:0]    ose,
  output logic                                good,
  input  logic                                good_ready,
  output logic                                busy
`ifdef SHA3_THETA_BYPASS_EN
  ,
  input  logic                                bypass
`endif
);

  typedef logic [NUM_LANES-1:0][LANE_W-1:0] row_w_t;
  typedef row_w_t [NUM_LANES-1:0]           state_t;  // [y][x]

  if (!(LANE_W inside {1, 2, 4, 8, 16, 32, 64})) begin : g_bad_lane_w
    $error("sha3_theta_pipe: illegal LANE_W %0d", LANE_W);
  end
  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
    $error("sha3_theta_pipe: illegal PIPE_STAGES %0d", PIPE_STAGES);
  end

  function automatic row_w_t theta_d(input row_w_t c);
    lane_t t;
    lane_t r;
    for (int x = 0; x < NUM_LANES; x++) begin
      t = '0;
      t[LANE_W-1:0] = c[(x + 1) % NUM_LANES];
      r = rotl1(t, LANE_W);
      theta_d[x] = c[(x + 4) % NUM_LANES] ^ r[LANE_W-1:0];
    end
  endfunction

  function automatic state_t theta_apply(input state_t a, input row_w_t d, input logic byp);
    for (int y = 0; y < NUM_LANES; y++) begin
      for (int x = 0; x < NUM_LANES; x++) begin
        theta_apply[y][x] = byp ? a[y][x] : (a[y][x] ^ d[x]);
      end
    end
  endfunction

  state_t a_in;
  row_w_t c_in;
  logic   byp_in;
  state_t out_data;
  logic   out_v;

  assign a_in = {ise, isd, isc, isb, isa};

`ifdef SHA3_THETA_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  sha3_theta_colpar #(.LANE_W(LANE_W)) u_colpar (
    .a (a_in),
    .c (c_in)
  );

  if (PIPE_STAGES == 1) begin : g_one
    state_t a_q, a_d;
    logic   v_q, v_d;
    logic   adv, ld;

    always_comb begin
      adv          = v_q && good_ready;
      sample_ready = !v_q || adv;
      ld           = sample && sample_ready;
      v_d          = ld || (v_q && !adv);
      a_d          = a_q;
      if (ld) a_d = theta_apply(a_in, theta_d(c_in), byp_in);
    end

    always_ff @(posedge clk or negedge rst) begin
      // NOTE: data registers are reset as well as valids, because the output
      // lanes are visible ports that must read zero straight out of reset.
      if (!rst) begin
        v_q <= 1'b0;
        a_q <= '0;
      end else begin
        // NOTE: state updates use non-blocking assignment so every flop sees
        // pre-edge values regardless of statement order.
        v_q <= v_d;
        a_q <= a_d;
      end
    end

    assign out_data = a_q;
    assign out_v    = v_q;
    assign busy     = v_q;
  end else begin : g_two
    // Stage 1 keeps A and its column parity; stage 2 holds A'.
    state_t s1_a_q, s1_a_d, s2_a_q, s2_a_d;
    row_w_t s1_c_q, s1_c_d;
    logic   s1_v_q, s1_v_d, s1_byp_q, s1_byp_d;
    logic   s2_v_q, s2_v_d;
    logic   s1_adv, s2_adv, ld1;

    always_comb begin
      s2_adv       = s2_v_q && good_ready;
      s1_adv       = s1_v_q && (!s2_v_q || s2_adv);
      sample_ready = !s1_v_q || s1_adv;
      ld1          = sample && sample_ready;

      s1_v_d   = ld1 || (s1_v_q && !s1_adv);
      s1_a_d   = s1_a_q;
      s1_c_d   = s1_c_q;
      s1_byp_d = s1_byp_q;
      if (ld1) begin
        s1_a_d   = a_in;
        s1_c_d   = c_in;
        s1_byp_d = byp_in;
      end

      s2_v_d = s1_adv || (s2_v_q && !s2_adv);
      s2_a_d = s2_a_q;
      if (s1_adv) s2_a_d = theta_apply(s1_a_q, theta_d(s1_c_q), s1_byp_q);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_v_q   <= 1'b0;
        s1_a_q   <= '0;
        s1_c_q   <= '0;
        s1_byp_q <= 1'b0;
        s2_v_q   <= 1'b0;
        s2_a_q   <= '0;
      end else begin
        s1_v_q   <= s1_v_d;
        s1_a_q   <= s1_a_d;
        s1_c_q   <= s1_c_d;
        s1_byp_q <= s1_byp_d;
        s2_v_q   <= s2_v_d;
        s2_a_q   <= s2_a_d;
      end
    end

    assign out_data = s2_a_q;
    assign out_v    = s2_v_q;
    assign busy     = s1_v_q || s2_v_q;
  end

  assign good = out_v;
  assign osa  = out_data[0];
  assign osb  = out_data[1];
  assign osc  = out_data[2];
  assign osd  = out_data[3];
  assign ose  = out_data[4];

endmodule
